// File: rtl/fifo_pad_pkg.sv
// rtl/fifo_pad_pkg.sv - shared helpers for the padded FIFO family
package fifo_pad_pkg;

   // Number of elements in one padded group.
   function automatic int group_len(input int pad_pre, input int lanes, input int pad_post);
      return pad_pre + lanes + pad_post;
   endfunction

   // Advance a pointer by step and wrap at depth by compare-and-subtract,
   // so depth need not be a power of two. step must not exceed depth.
   function automatic int ptr_inc(input int ptr, input int step, input int depth);
      int sum;
      sum = ptr + step;
      if (sum >= depth) begin
         sum = sum - depth;
      end
      return sum;
   endfunction

endpackage

// File: rtl/fifo_pad_serial_if.sv
// rtl/fifo_pad_serial_if.sv - input word and output element handshakes
interface fifo_pad_serial_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4
) ();
   logic                        pad_en;
   logic                        in_valid;
   logic                        in_ready;
   logic [LANES*DATA_WIDTH-1:0] in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [DATA_WIDTH-1:0]       out_data;
   logic                        out_last;

   // Producer of input words and consumer of output elements.
   modport master (
      output pad_en, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   // The FIFO itself.
   modport slave (
      input  pad_en, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fifo_pad_serial.sv
// rtl/fifo_pad_serial.sv - word-in, element-out FIFO with optional zero padding per group
module fifo_pad_serial
   import fifo_pad_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int PAD_PRE    = 3,
   parameter int PAD_POST   = 1,
   parameter int GROUPS     = 2,
   localparam int G         = group_len(PAD_PRE, LANES, PAD_POST),
   localparam int DEPTH     = GROUPS * G,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   fifo_pad_serial_if.slave bus,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem  [DEPTH];
   logic                  lst  [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;

   logic [CW-1:0]         geff;
   logic                  do_wr;
   logic                  do_rd;

   // Per-slot view of the group about to be written: element, last flag,
   // enable and wrapped storage index for each of the up to G slots.
   logic [DATA_WIDTH-1:0] pad_elem [G];
   logic [DATA_WIDTH-1:0] raw_elem [G];
   logic [DATA_WIDTH-1:0] wdata    [G];
   logic                  wlast    [G];
   logic                  wen      [G];
   logic [PW-1:0]         wr_idx   [G];

   for (genvar i = 0; i < G; i++) begin : g_slot
      if (i < PAD_PRE || i >= PAD_PRE + LANES) begin : g_pad_zero
         assign pad_elem[i] = '0;
      end else begin : g_pad_lane
         assign pad_elem[i] = bus.in_data[(LANES-1-(i-PAD_PRE))*DATA_WIDTH +: DATA_WIDTH];
      end
      if (i < LANES) begin : g_raw_lane
         assign raw_elem[i] = bus.in_data[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_raw_zero
         assign raw_elem[i] = '0;
      end
      assign wdata[i]  = bus.pad_en ? pad_elem[i] : raw_elem[i];
      assign wlast[i]  = bus.pad_en ? (i == G - 1) : (i == LANES - 1);
      assign wen[i]    = bus.pad_en || (i < LANES);
      assign wr_idx[i] = PW'(ptr_inc(int'(wr_ptr), i, DEPTH));
   end

   // Space check uses only the registered count, so a same-cycle read never opens the input.
   assign geff         = bus.pad_en ? CW'(G) : CW'(LANES);
   assign bus.in_ready = (DEPTH_C - count) >= geff;
   assign do_wr        = bus.in_valid && bus.in_ready;

   assign empty         = (count == '0);
   assign full          = (count == DEPTH_C);
   assign bus.out_valid = !empty;
   assign do_rd         = bus.out_valid && bus.out_ready;
   assign bus.out_data  = empty ? '0 : mem[rd_ptr];
   assign bus.out_last  = empty ? 1'b0 : lst[rd_ptr];

   // Pointers, occupancy and group storage; reset clears control only.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            for (int i = 0; i < G; i++) begin
               if (wen[i]) begin
                  mem[wr_idx[i]] <= wdata[i];
                  lst[wr_idx[i]] <= wlast[i];
               end
            end
            wr_ptr <= PW'(ptr_inc(int'(wr_ptr), int'(geff), DEPTH));
         end
         if (do_rd) begin
            rd_ptr <= PW'(ptr_inc(int'(rd_ptr), 1, DEPTH));
         end
         count <= count + (do_wr ? geff : '0) - CW'(do_rd);
      end
   end

endmodule

// File: tb/tb_fifo_pad_serial.sv
// tb/tb_fifo_pad_serial.sv - scoreboard bench for fifo_pad_serial
module tb_fifo_pad_serial;

   localparam int DW       = 8;
   localparam int LANES    = 4;
   localparam int PAD_PRE  = 3;
   localparam int PAD_POST = 1;
   localparam int G        = PAD_PRE + LANES + PAD_POST;
   localparam int DEPTH    = 2 * G;

   logic       clk;
   logic       rst;
   logic [4:0] count;
   logic       full;
   logic       empty;

   int checks;
   int errors;
   int q[$];
   int pre_count;
   logic mon_en;

   fifo_pad_serial_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

   fifo_pad_serial #(
      .DATA_WIDTH(DW), .LANES(LANES), .PAD_PRE(PAD_PRE), .PAD_POST(PAD_POST), .GROUPS(2)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: expected element stream of one accepted word, entries are {last, data}.
   task automatic push_group(input logic pad, input logic [31:0] d);
      int elems[$];
      if (pad) for (int k = 0; k < PAD_PRE; k++) elems.push_back(0);
      for (int k = 0; k < LANES; k++) elems.push_back(int'((d >> (DW * (LANES - 1 - k))) & 32'hFF));
      if (pad) for (int k = 0; k < PAD_POST; k++) elems.push_back(0);
      elems[elems.size() - 1] = elems[elems.size() - 1] | 256;
      foreach (elems[k]) q.push_back(elems[k]);
   endtask

   // One stimulus cycle: drive, check in_ready against free space, record accepted word.
   task automatic cycle(input logic v, input logic p, input logic [31:0] d, input logic ordy,
                        output logic acc);
      int geff;
      logic exp_rdy;
      @(negedge clk);
      bus.in_valid  = v;
      bus.pad_en    = p;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #2;
      geff    = p ? G : LANES;
      exp_rdy = (DEPTH - pre_count) >= geff;
      chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
      acc = v && bus.in_ready;
      if (v && exp_rdy) push_group(p, d);
   endtask

   task automatic drain();
      logic acc;
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b1, acc);
         n++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   // Monitor: compares occupancy flags and pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      int e;
      #1;
      if (mon_en) begin
         pre_count = q.size();
         chk("count", int'(count), q.size());
         chk("empty", int'(empty), int'(q.size() == 0));
         chk("full", int'(full), int'(q.size() == DEPTH));
         chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("out_data", int'(bus.out_data), e & 255);
               chk("out_last", int'(bus.out_last), e >> 8);
            end
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_out_last", int'(bus.out_last), 0);
   endtask

   initial begin
      logic acc;
      int tries;
      checks        = 0;
      errors        = 0;
      pre_count     = 0;
      mon_en        = 1'b0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.pad_en    = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_state();
      rst    = 1'b0;
      mon_en = 1'b1;

      // Single padded group streamed out with out_ready held high.
      cycle(1'b1, 1'b1, 32'hAABBCCDD, 1'b1, acc);
      drain();

      // Fill with two padded groups, then a blocked third word.
      cycle(1'b1, 1'b1, $urandom, 1'b0, acc);
      cycle(1'b1, 1'b1, $urandom, 1'b0, acc);
      cycle(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, acc);
      chk("blocked_accept", int'(acc), 0);
      cycle(1'b0, 1'b1, 32'h0, 1'b0, acc);
      drain();

      // Write and read together at count 8.
      cycle(1'b1, 1'b1, $urandom, 1'b0, acc);
      cycle(1'b1, 1'b1, $urandom, 1'b1, acc);
      cycle(1'b0, 1'b1, 32'h0, 1'b0, acc);
      drain();

      // Unpadded write, then free-space checks at count 12.
      cycle(1'b1, 1'b0, 32'h01020304, 1'b0, acc);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, acc);
      drain();
      cycle(1'b1, 1'b1, $urandom, 1'b0, acc);
      cycle(1'b1, 1'b0, $urandom, 1'b0, acc);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, acc);
      cycle(1'b0, 1'b1, 32'h0, 1'b0, acc);
      drain();

      // Alternating modes with random consumer back-pressure, many wraps.
      for (int i = 0; i < 60; i++) begin
         tries = 0;
         acc   = 1'b0;
         while (!acc && tries < 50) begin
            cycle(1'b1, logic'(i % 2), $urandom, logic'($urandom_range(0, 1)), acc);
            tries++;
         end
         chk("write_timeout", int'(acc), 1);
         if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 32'h0, logic'($urandom_range(0, 1)), acc);
      end
      drain();

      // Reset with five elements still stored.
      cycle(1'b1, 1'b1, $urandom, 1'b0, acc);
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1, acc);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, acc);
      @(negedge clk);
      mon_en       = 1'b0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      check_reset_state();
      q.delete();
      pre_count = 0;
      rst       = 1'b0;
      #1;
      mon_en = 1'b1;
      cycle(1'b1, 1'b1, 32'hAABBCCDD, 1'b1, acc);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_pad_serial.md
FIFO_PAD_SERIAL -- requirements
Module: fifo_pad_serial

Interface
REQ-001 Parameter DATA_WIDTH, default 8: element width in bits.
REQ-002 Parameter LANES, default 4: elements per input word, LANES >= 1.
REQ-003 Parameter PAD_PRE, default 3: zero elements inserted before each padded group.
REQ-004 Parameter PAD_POST, default 1: zero elements inserted after each padded group.
REQ-005 Parameter GROUPS, default 2: storage depth in padded groups.
REQ-006 Derived constants: G = PAD_PRE+LANES+PAD_POST; DEPTH = GROUPS*G (default 16, not required to be a power of two).
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 pad_en  in  1  1 = write padded group of G elements; 0 = write LANES elements only.
REQ-010 in_valid  in  1  input word offered.
REQ-011 in_ready  out  1  input word can be accepted this cycle.
REQ-012 in_data  in  LANES*DATA_WIDTH  packed word; the most-significant lane is emitted first.
REQ-013 out_valid  out  1  out_data holds a stored element.
REQ-014 out_ready  in  1  consumer takes out_data this cycle.
REQ-015 out_data  out  DATA_WIDTH  head element.
REQ-016 out_last  out  1  head element is the final element of its group.
REQ-017 count  out  $clog2(DEPTH+1)  occupied entries.
REQ-018 full, empty  out  1 each  count==DEPTH, count==0.

Function
REQ-019 Geff SHALL equal G when pad_en=1 and LANES when pad_en=0, evaluated in the cycle of the write.
REQ-020 in_ready SHALL equal (DEPTH-count >= Geff), combinational from count and pad_en.
REQ-021 A write SHALL occur only when in_valid&&in_ready, storing Geff entries from wr_ptr in this order: PAD_PRE zeros (padded only), lanes MSB-first, PAD_POST zeros (padded only).
REQ-022 A per-entry last flag SHALL be stored; it is set only on the final entry of each written group.
REQ-023 The output SHALL be first-word-fall-through: out_valid = !empty; out_data and out_last reflect entry rd_ptr; when empty, out_data=0 and out_last=0.
REQ-024 A read SHALL occur only when out_valid&&out_ready and SHALL advance rd_ptr by 1.
REQ-025 A written element SHALL be visible at the output no earlier than the cycle after its write.
REQ-026 Pointers SHALL wrap explicitly at DEPTH (compare-and-subtract, not modulo of a power of two); a group MAY straddle the wrap.
REQ-027 count update: +Geff on write only; -1 on read only; +Geff-1 on simultaneous write and read.
REQ-028 A read in the same cycle SHALL NOT make in_ready true in that cycle; in_ready uses registered count only.
REQ-029 in_valid while in_ready=0 SHALL change no state; the source holds the word.
REQ-030 Element order at the output SHALL equal write order across groups, modes and wrap-around.

Reset
REQ-031 On rst=1 at a clock edge: rd_ptr=0, wr_ptr=0, count=0; therefore empty=1, full=0, out_valid=0, out_data=0, out_last=0.
REQ-032 Reset mid-operation SHALL discard all contents; storage and flag arrays are not reset.
REQ-033 rst SHALL take priority over simultaneous write and read.

Structure
REQ-034 Package fifo_pad_pkg SHALL hold a group-length function (PAD_PRE, LANES, PAD_POST) and a pointer-wrap-increment function shared with sibling FIFOs.
REQ-035 No sub-module; storage and control SHALL be inline, with one always_ff block for state and combinational flags.

Verification (defaults: G=8, DEPTH=16)
REQ-036 Reset; write 0xAABBCCDD with pad_en=1; hold out_ready=1 -> outputs 00,00,00,AA,BB,CC,DD,00 on consecutive cycles; out_last only on the 8th; count goes 8->0.
REQ-037 Two padded writes, no reads -> count=16, full=1, in_ready=0; a third in_valid leaves count=16 and the contents unchanged.
REQ-038 count=8; padded write and read in the same cycle -> count=15, in_ready=0 on the next cycle.
REQ-039 pad_en=0; write 0x01020304 -> outputs 01,02,03,04 with out_last on 04; count=4. With count=12, pad_en=0 in_ready=1 and pad_en=1 in_ready=0.
REQ-040 Alternate pad_en=1 and pad_en=0 writes with random out_ready over more than 40 cycles, forcing wraps -> output sequence matches the scoreboard exactly.
REQ-041 Assert rst with count=5 mid-stream -> next cycle count=0, empty=1, out_valid=0, out_data=0; a subsequent write behaves as in REQ-036.
